// File: rtl/fu_issue_scoreboard_if.sv
// fu_issue_scoreboard_if: ID-issue, FU launch/done and writeback bundle between the ID stage, the FUs and the scoreboard
interface fu_issue_scoreboard_if #(
   parameter int NUM_FU = 5,
   parameter int FU_W = 3
);
   logic issue_valid;
   logic [FU_W-1:0] issue_fu;
   logic [4:0] issue_rs1;
   logic [4:0] issue_rs2;
   logic issue_use_rs1;
   logic issue_use_rs2;
   logic [4:0] issue_rd;
   logic issue_we;
   logic issue_ready;
   logic [NUM_FU-1:0] fu_en;
   logic [NUM_FU-1:0] fu_done;
   logic wb_valid;
   logic [FU_W-1:0] wb_fu;
   logic [4:0] wb_rd;
   logic wb_we;
   modport master (
      output issue_valid, issue_fu, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2, issue_rd, issue_we, fu_done,
      input issue_ready, fu_en, wb_valid, wb_fu, wb_rd, wb_we
   );
   modport slave (
      input issue_valid, issue_fu, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2, issue_rd, issue_we, fu_done,
      output issue_ready, fu_en, wb_valid, wb_fu, wb_rd, wb_we
   );
endinterface

// File: rtl/fu_issue_scoreboard.sv
// fu_issue_scoreboard: RAW/WAW/busy issue checks for NUM_FU units with round-robin writeback arbitration
module fu_issue_scoreboard #(
   parameter int NUM_FU = 5,
   parameter int FU_W = 3,
   parameter int CNT_W = 32
) (
   input  logic clk,
   input  logic rst,
   fu_issue_scoreboard_if.slave sb,
   output logic [NUM_FU-1:0] busy_vec,
   output logic [CNT_W-1:0] stall_cnt,
   output logic err
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} fu_state_t;
   fu_state_t [NUM_FU-1:0] state;
   logic [NUM_FU-1:0][4:0] rd_q;
   logic [NUM_FU-1:0] we_q, fu_hit, gnt_vec, done_ok;
   logic [FU_W-1:0] rr_ptr, gnt;
   logic [31:0] pending;
   logic [4:0] gnt_rd;
   logic gnt_ok, gnt_we, hazard;

   always_comb begin
      pending = '0;
      busy_vec = '0;
      fu_hit = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         busy_vec[i] = state[i] != IDLE;
         fu_hit[i] = sb.issue_fu == FU_W'(i);
         if (busy_vec[i] && we_q[i]) pending[rd_q[i]] = 1'b1;
      end
      pending[0] = 1'b0;
   end

   // out-of-range FU indices hit no unit, so they can never be ready
   assign hazard = (sb.issue_use_rs1 && pending[sb.issue_rs1]) ||
                   (sb.issue_use_rs2 && pending[sb.issue_rs2]) ||
                   (sb.issue_we && pending[sb.issue_rd]);
   assign sb.issue_ready = sb.issue_valid && |(fu_hit & ~busy_vec) && !hazard;
   assign sb.fu_en = sb.issue_ready ? fu_hit : '0;

   always_comb begin
      gnt_ok = 1'b0;
      gnt = '0;
      gnt_rd = '0;
      gnt_we = 1'b0;
      gnt_vec = '0;
      done_ok = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         if (!gnt_ok && state[(int'(rr_ptr) + k) % NUM_FU] == DONE) begin
            gnt_ok = 1'b1;
            gnt = FU_W'((int'(rr_ptr) + k) % NUM_FU);
         end
      end
      for (int i = 0; i < NUM_FU; i++) begin
         done_ok[i] = state[i] == EXEC || sb.fu_en[i];
         if (gnt_ok && gnt == FU_W'(i)) begin
            gnt_vec[i] = 1'b1;
            gnt_rd = rd_q[i];
            gnt_we = we_q[i];
         end
      end
   end

   assign sb.wb_valid = gnt_ok;
   assign sb.wb_fu = gnt;
   assign sb.wb_rd = gnt_rd;
   assign sb.wb_we = gnt_we && gnt_rd != 5'd0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= {NUM_FU{IDLE}};
         rd_q <= '0;
         we_q <= '0;
         rr_ptr <= '0;
         stall_cnt <= '0;
         err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (sb.fu_en[i]) begin
               state[i] <= sb.fu_done[i] ? DONE : EXEC;
               rd_q[i] <= sb.issue_rd;
               we_q[i] <= sb.issue_we;
            end else if (state[i] == EXEC && sb.fu_done[i]) state[i] <= DONE;
            else if (gnt_vec[i]) state[i] <= IDLE;
         end
         if (gnt_ok) rr_ptr <= gnt == FU_W'(NUM_FU - 1) ? '0 : gnt + 1'b1;
         if (sb.issue_valid && !sb.issue_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
         err <= err || |(sb.fu_done & ~done_ok);
      end
   end
endmodule

// File: tb/tb_fu_issue_scoreboard.sv
// tb_fu_issue_scoreboard: directed hazard, round-robin, error and reset vectors for fu_issue_scoreboard
module tb_fu_issue_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [4:0] busy_vec;
   logic [31:0] stall_cnt;
   logic err;
   int checks = 0;
   int errors = 0;
   int exp_fu [2][3] = '{'{0, 2, 4}, '{4, 0, 2}};

   always #5 clk = ~clk;

   fu_issue_scoreboard_if #(.NUM_FU(5), .FU_W(3)) bus ();

   fu_issue_scoreboard #(.NUM_FU(5), .FU_W(3), .CNT_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .sb(bus),
      .busy_vec(busy_vec),
      .stall_cnt(stall_cnt),
      .err(err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0;
      bus.issue_fu = '0;
      bus.issue_rs1 = '0;
      bus.issue_rs2 = '0;
      bus.issue_use_rs1 = 1'b0;
      bus.issue_use_rs2 = 1'b0;
      bus.issue_rd = '0;
      bus.issue_we = 1'b0;
      bus.fu_done = '0;
   endtask

   task automatic present(input logic [2:0] fu, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic we);
      bus.issue_valid = 1'b1;
      bus.issue_fu = fu;
      bus.issue_rd = rd;
      bus.issue_rs1 = rs1;
      bus.issue_rs2 = rs2;
      bus.issue_use_rs1 = u1;
      bus.issue_use_rs2 = u2;
      bus.issue_we = we;
      #1;
   endtask

   task automatic launch(input logic [2:0] fu, input logic [4:0] rd);
      present(fu, rd, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      check("launch_ready", bus.issue_ready, 1);
      tick();
      bus.issue_valid = 1'b0;
   endtask

   task automatic pass(input logic [2:0] fu, input logic [4:0] rd);
      launch(fu, rd);
      bus.fu_done = 5'd1 << fu;
      tick();
      bus.fu_done = '0;
      tick();
   endtask

   initial begin
      idle();
      #12;
      check("rst_busy", busy_vec, 0);
      check("rst_wb_valid", bus.wb_valid, 0);
      check("rst_wb_we", bus.wb_we, 0);
      check("rst_wb_fu", bus.wb_fu, 0);
      check("rst_wb_rd", bus.wb_rd, 0);
      check("rst_stall", stall_cnt, 0);
      check("rst_err", err, 0);
      rst = 1'b1;
      tick();
      // basic ALU issue and writeback
      present(3'd0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      check("alu_ready", bus.issue_ready, 1);
      check("alu_fu_en", bus.fu_en, 5'b00001);
      tick();
      bus.issue_valid = 1'b0;
      check("alu_busy", busy_vec, 5'b00001);
      tick();
      tick();
      bus.fu_done = 5'b00001;
      #1;
      check("alu_no_wb_yet", bus.wb_valid, 0);
      tick();
      bus.fu_done = '0;
      check("alu_wb_valid", bus.wb_valid, 1);
      check("alu_wb_fu", bus.wb_fu, 0);
      check("alu_wb_rd", bus.wb_rd, 5);
      check("alu_wb_we", bus.wb_we, 1);
      tick();
      check("alu_busy_clear", busy_vec, 0);
      check("alu_wb_done", bus.wb_valid, 0);
      // RAW on mul result
      launch(3'd2, 5'd7);
      present(3'd0, 5'd8, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1);
      check("raw_stall", bus.issue_ready, 0);
      tick();
      tick();
      bus.fu_done = 5'b00100;
      tick();
      bus.fu_done = '0;
      check("raw_stall_wb", bus.issue_ready, 0);
      check("mul_wb_fu", bus.wb_fu, 2);
      check("mul_wb_rd", bus.wb_rd, 7);
      tick();
      check("raw_release", bus.issue_ready, 1);
      check("raw_fu_en", bus.fu_en, 5'b00001);
      check("raw_stall_cnt", stall_cnt, 4);
      tick();
      bus.issue_valid = 1'b0;
      check("raw_stall_hold", stall_cnt, 4);
      check("raw_busy", busy_vec, 5'b00001);
      bus.fu_done = 5'b00001;
      tick();
      bus.fu_done = '0;
      check("raw_wb_fu", bus.wb_fu, 0);
      check("raw_wb_rd", bus.wb_rd, 8);
      tick();
      check("raw_busy_clear", busy_vec, 0);
      // WAW, busy FU and x0 destination
      launch(3'd3, 5'd3);
      present(3'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      check("waw_stall", bus.issue_ready, 0);
      present(3'd3, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      check("busy_fu_stall", bus.issue_ready, 0);
      present(3'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      check("x0_ready", bus.issue_ready, 1);
      check("x0_fu_en", bus.fu_en, 5'b00001);
      tick();
      bus.issue_valid = 1'b0;
      bus.fu_done = 5'b00001;
      tick();
      bus.fu_done = '0;
      check("x0_wb_valid", bus.wb_valid, 1);
      check("x0_wb_rd", bus.wb_rd, 0);
      check("x0_wb_we", bus.wb_we, 0);
      tick();
      bus.fu_done = 5'b01000;
      tick();
      bus.fu_done = '0;
      check("div_wb_fu", bus.wb_fu, 3);
      check("div_wb_rd", bus.wb_rd, 3);
      check("div_wb_we", bus.wb_we, 1);
      tick();
      check("div_busy_clear", busy_vec, 0);
      // round robin, first from pointer 0 then from pointer 3
      pass(3'd4, 5'd1);
      for (int r = 0; r < 2; r++) begin
         launch(3'd0, 5'd10);
         launch(3'd2, 5'd11);
         launch(3'd4, 5'd12);
         bus.fu_done = 5'b10101;
         tick();
         bus.fu_done = '0;
         for (int k = 0; k < 3; k++) begin
            check("rr_fu", bus.wb_fu, exp_fu[r][k]);
            check("rr_rd", bus.wb_rd, 10 + exp_fu[r][k] / 2);
            tick();
         end
         check("rr_drained", bus.wb_valid, 0);
         if (r == 0) pass(3'd2, 5'd1);
      end
      // protocol error and illegal FU index
      check("err_clear", err, 0);
      bus.fu_done = 5'b00010;
      tick();
      bus.fu_done = '0;
      check("err_set", err, 1);
      tick();
      check("err_sticky", err, 1);
      for (int f = 5; f < 8; f++) begin
         present(3'(f), 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         check("bad_fu_ready", bus.issue_ready, 0);
         check("bad_fu_en", bus.fu_en, 0);
      end
      idle();
      // asynchronous reset with work in flight
      launch(3'd0, 5'd5);
      launch(3'd1, 5'd6);
      launch(3'd2, 5'd7);
      bus.fu_done = 5'b00010;
      tick();
      bus.fu_done = '0;
      check("pre_rst_busy", busy_vec, 5'b00111);
      check("pre_rst_wb_fu", bus.wb_fu, 1);
      check("pre_rst_stall", stall_cnt, 4);
      #3;
      rst = 1'b0;
      #1;
      check("async_busy", busy_vec, 0);
      check("async_wb_valid", bus.wb_valid, 0);
      check("async_wb_rd", bus.wb_rd, 0);
      check("async_wb_we", bus.wb_we, 0);
      check("async_err", err, 0);
      check("async_stall", stall_cnt, 0);
      bus.fu_done = 5'b00111;
      tick();
      bus.fu_done = '0;
      #2;
      rst = 1'b1;
      #1;
      check("post_rst_busy", busy_vec, 0);
      check("post_rst_wb", bus.wb_valid, 0);
      present(3'd0, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1);
      check("post_rst_ready0", bus.issue_ready, 1);
      present(3'd1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1);
      check("post_rst_ready1", bus.issue_ready, 1);
      check("post_rst_fu_en", bus.fu_en, 5'b00010);
      idle();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fu_issue_scoreboard.md
Name: fu_issue_scoreboard

Overview:
- Parametrised issue/writeback scoreboard for the multi-functional-unit RV32 core. It replaces the single-instruction-in-flight control with tracking for up to NUM_FU concurrently busy FUs.
- Sits between the ID stage and the FUs. It decides whether the ID instruction can issue, checking RAW, WAW and FU-busy hazards.
- It launches the selected FU and arbitrates FU results onto the single register-file write port using round-robin.
- It also keeps a saturating stall-cycle counter for the debug mux.

Parameters:
- NUM_FU, 5, number of functional units (2..8); index 0 = ALU, 1 = mem, 2 = mul, 3 = div, 4 = jump in the default core.
- FU_W, 3, width of FU index; must be at least clog2(NUM_FU).
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- issue_valid  in  1  ID holds a valid decoded instruction.
- issue_fu  in  FU_W  target FU index; values >= NUM_FU are never ready.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_use_rs1  in  1  instruction reads rs1.
- issue_use_rs2  in  1  instruction reads rs2.
- issue_rd  in  5  destination register.
- issue_we  in  1  instruction writes rd.
- issue_ready  out  1  instruction may issue this cycle (combinational).
- fu_en  out  NUM_FU  one-hot launch pulse to the FUs (combinational).
- fu_done  in  NUM_FU  one-cycle completion pulse per FU; the result is latched in that FU's WB register on the same edge.
- wb_valid  out  1  a completed FU is granted writeback this cycle.
- wb_fu  out  FU_W  granted FU index; drives the write-data mux select.
- wb_rd  out  5  write address.
- wb_we  out  1  register-file write enable (wb_valid & we & rd != 0).
- busy_vec  out  NUM_FU  per-FU busy flags.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- err  out  1  sticky protocol error.

Behaviour:
- Per-FU state: a 3-state FSM with states IDLE, EXEC and DONE, plus the captured rd[4:0] and we.
  - busy_vec[i] = (state != IDLE).
- pending[r] = OR over i of (state_i != IDLE & we_i & rd_i == r), for r = 1..31. pending[0] is always 0.
- issue_ready = issue_valid & issue_fu < NUM_FU & state[issue_fu] == IDLE & no RAW & no WAW.
  - No RAW: !(use_rs1 & pending[rs1]) and !(use_rs2 & pending[rs2]).
  - No WAW: !(issue_we & pending[issue_rd]).
  - All hazard checks use registered state only. There is no same-cycle bypass from writeback.
- fu_en[issue_fu] = issue_ready. Every other fu_en bit is 0.
- On an edge with fu_en[i]: state_i IDLE->EXEC; capture rd_i <= issue_rd and we_i <= issue_we.
- On an edge with fu_done[i] and state_i == EXEC: EXEC->DONE.
- fu_done[i] with state_i != EXEC is ignored, and err <= 1.
- fu_done[i] in the same cycle as fu_en[i]: the FU is treated as zero-latency and goes IDLE->DONE.
- Writeback arbitration:
  - Round-robin over FUs in DONE, searching from rr_ptr upward with wrap.
  - Grant g gives wb_valid = 1, wb_fu = g, wb_rd = rd_g, and wb_we = we_g & (rd_g != 0).
  - At the edge: state_g DONE->IDLE and rr_ptr <= (g+1) mod NUM_FU.
  - With no grant: wb_valid = 0 and wb_fu/wb_rd = 0.
  - One grant per cycle. Ungranted DONE units wait; a fairness bound of NUM_FU-1 cycles is guaranteed.
- A dependent instruction sees issue_ready rise in the cycle after its producer's writeback edge.
  - Minimum producer-to-consumer spacing is fu_done edge -> WB edge -> issue: 2 edges.
- An FU is re-issuable the cycle after its writeback edge. Issue to an FU being granted in the same cycle is blocked.
- stall_cnt increments on each edge where issue_valid & !issue_ready, and saturates at all-ones.
- Reset (async, rst = 0), mid-operation included:
  - All FU states go to IDLE, rd/we = 0, rr_ptr = 0, stall_cnt = 0, err = 0.
  - Outputs in reset: busy_vec = 0, wb_valid = 0, wb_we = 0, wb_fu = 0, wb_rd = 0, fu_en = 0 unless issue_valid.
  - FU done pulses that arrive during reset are discarded.

Test Plan:
- Reset idle, then issue_valid with fu = 0, rd = 5, rs1 = 1, rs2 = 2 -> issue_ready = 1 and fu_en = 00001. fu_done[0] two cycles later -> next cycle wb_valid = 1, wb_fu = 0, wb_rd = 5, wb_we = 1, then busy_vec = 0.
- RAW: issue mul (fu 2), rd = 7, then an ALU op with rs2 = 7 -> issue_ready = 0 until the cycle after mul writeback; stall_cnt equals the stalled cycle count exactly.
- WAW plus x0: div rd = 3 in flight, then an ALU op with rd = 3 -> stalled. An ALU op with rd = 0 and rs1 = 0 -> issues immediately; its writeback has wb_we = 0.
- Round-robin: fu_done on FUs 0, 2 and 4 on the same edge -> grants on successive cycles in order 0, 2, 4. Repeat with rr_ptr = 3 -> order 4, 0, 2.
- Structural/error: issue to busy FU 3 -> ready = 0. fu_done[1] while FU 1 is IDLE -> err = 1 and sticky. issue_fu = 6 with NUM_FU = 5 -> never ready.
- Reset mid-operation: three FUs in EXEC/DONE, rst pulled low asynchronously mid-cycle -> busy_vec = 0 and wb_valid = 0 immediately, before the next edge. Release -> all issue_ready conditions clear.
